// File: rtl/fc_fm_packer.sv
// Packs a stream of int8 feature bytes into 64-bit fm memory words, one frame per request.
// Write strobe lands one cycle after the lane-7 byte; o_frame_done pulses two cycles after the frame's last byte.
module fc_fm_packer #(
    parameter int FRAME_WORDS = 48,
    parameter int ADDR_STRIDE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_start,
    input  logic [8:0]  i_fm_base_addr,
    input  logic        i_fm_valid,
    input  logic [7:0]  i_fm_data,
    output logic        o_fm_ready,
    output logic        o_fm_wr_en,
    output logic [15:0] o_fm_wr_addr,
    output logic [63:0] o_fm_wr_data,
    output logic        o_frame_done,
    output logic        o_busy
);
    localparam int              WCW       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS + 1) : 1;
    localparam logic [15:0]     STRIDE    = 16'(ADDR_STRIDE);
    localparam logic [WCW-1:0]  LAST_WORD = WCW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

    state_t         state_q;
    logic [2:0]     byte_cnt_q;
    logic [WCW-1:0] word_cnt_q;
    logic [8:0]     base_q;
    logic [63:0]    word_q;
    logic           wr_en_q;
    logic [15:0]    wr_addr_q;
    logic [63:0]    wr_data_q;
    logic [15:0]    wr_addr_d;

    // Product is taken in 16 bits so the address wraps modulo 2^16.
    assign wr_addr_d = {7'd0, base_q} + STRIDE * 16'(word_cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            base_q     <= '0;
            word_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_frame_start) begin
                        base_q     <= i_fm_base_addr;
                        byte_cnt_q <= '0;
                        word_cnt_q <= '0;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (i_fm_valid) begin
                        word_q[{byte_cnt_q, 3'b000} +: 8] <= i_fm_data;
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd7) begin
                            // Lane 7 bypasses word_q so the next byte can start a new word at once.
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= wr_addr_d;
                            wr_data_q  <= {i_fm_data, word_q[55:0]};
                            word_cnt_q <= word_cnt_q + 1'b1;
                            if (word_cnt_q == LAST_WORD) begin
                                state_q <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_fm_ready   = (state_q == FILL);
    assign o_busy       = (state_q == FILL) || (state_q == FLUSH);
    assign o_frame_done = (state_q == DONE);
    assign o_fm_wr_en   = wr_en_q;
    assign o_fm_wr_addr = wr_addr_q;
    assign o_fm_wr_data = wr_data_q;

endmodule
